// File: rtl/key_tone_pkg.sv
// Shared types, constants and the half-period helper for the keypad tone generator.
package key_tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [3:0] KEY_STOP = 4'd15;
  localparam int unsigned NUM_NOTES = 15;
  localparam int unsigned CNT_W = 32;

  // C major scale, C4..C6, in Hz
  localparam int unsigned NOTE_FREQ [0:14] = '{
    262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 1047
  };

  // Square-wave half-period in clk cycles, floored, never below one cycle
  function automatic logic [CNT_W-1:0] note_half(input logic [3:0] idx, input int unsigned clk_hz);
    int unsigned h;
    if (idx == KEY_STOP) begin
      return CNT_W'(1);
    end
    h = clk_hz / (2 * NOTE_FREQ[idx]);
    return (h == 0) ? CNT_W'(1) : CNT_W'(h);
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles wave every half_period cycles while enabled.
module tone_divider
  import key_tone_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [CNT_W-1:0] half_period,
  input  logic             en,
  output logic             wave
);

  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic             wave_q, wave_d;

  always_comb begin
    half_cnt_d = half_cnt_q;
    wave_d     = wave_q;
    if (restart) begin
      // a fresh note always starts on the high half
      wave_d     = 1'b1;
      half_cnt_d = '0;
    end else if (!en) begin
      wave_d     = 1'b0;
      half_cnt_d = '0;
    end else if (half_cnt_q == half_period - CNT_W'(1)) begin
      wave_d     = ~wave_q;
      half_cnt_d = '0;
    end else begin
      half_cnt_d = half_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_cnt_q <= '0;
      wave_q     <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      wave_q     <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/key_tone_gen.sv
// Plays one note per accepted key code: square wave for the note length, then a silent gap.
module key_tone_gen
  import key_tone_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned NOTE_MS = 250,
  parameter int unsigned GAP_MS  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       buzz,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       note_done
);

  localparam int unsigned NOTE_RAW = CLK_HZ / 1000 * NOTE_MS;
  localparam int unsigned GAP_RAW  = CLK_HZ / 1000 * GAP_MS;
  localparam int unsigned NOTE_CYC = (NOTE_RAW == 0) ? 1 : NOTE_RAW;
  localparam int unsigned GAP_CYC  = (GAP_RAW == 0) ? 1 : GAP_RAW;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [3:0]       note_idx_q, note_idx_d;
  logic             note_done_q, note_done_d;
  logic             busy_q, busy_d;
  logic             restart_c;
  logic             tone_en_c;
  logic [CNT_W-1:0] half_tab [16];
  logic [CNT_W-1:0] half_c;

  // Half-period table folded to constants at elaboration
  for (genvar i = 0; i < 16; i++) begin : g_half
    localparam logic [CNT_W-1:0] HALF = note_half(4'(i), CLK_HZ);
    assign half_tab[i] = HALF;
  end

  assign half_c = half_tab[note_idx_q];

  always_comb begin
    state_d     = state_q;
    dur_d       = dur_q;
    note_idx_d  = note_idx_q;
    note_done_d = 1'b0;
    restart_c   = 1'b0;
    // a key strobe overrides any timer event on the same edge
    if (key_valid && key_code != KEY_STOP) begin
      restart_c  = 1'b1;
      note_idx_d = key_code;
      dur_d      = '0;
      state_d    = PLAY;
    end else if (key_valid) begin
      dur_d   = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (dur_q == NOTE_LAST) begin
            dur_d       = '0;
            note_done_d = 1'b1;
            state_d     = GAP;
          end else begin
            dur_d = dur_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (dur_q == GAP_LAST) begin
            dur_d   = '0;
            state_d = IDLE;
          end else begin
            dur_d = dur_q + CNT_W'(1);
          end
        end
        default: begin
          dur_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    busy_d    = (state_d != IDLE);
    tone_en_c = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dur_q       <= '0;
      note_idx_q  <= '0;
      note_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      note_idx_q  <= note_idx_d;
      note_done_q <= note_done_d;
      busy_q      <= busy_d;
    end
  end

  tone_divider u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart_c),
    .half_period(half_c),
    .en         (tone_en_c),
    .wave       (buzz)
  );

  assign busy      = busy_q;
  assign note_idx  = note_idx_q;
  assign note_done = note_done_q;

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed bench for key_tone_gen with NOTE_CYC=2000, GAP_CYC=1000 at a 1 MHz clock.
module tb_key_tone_gen;

  localparam int NOTE_CYC = 2000;
  localparam int GAP_CYC  = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       buzz;
  logic       busy;
  logic [3:0] note_idx;
  logic       note_done;

  int total = 0;
  int bad   = 0;

  key_tone_gen #(
    .CLK_HZ (1_000_000),
    .NOTE_MS(2),
    .GAP_MS (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .buzz     (buzz),
    .busy     (busy),
    .note_idx (note_idx),
    .note_done(note_done)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample/drive 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    key_code  = 4'hA;
  endtask

  // Expected waveform k cycles after the starting strobe edge
  function automatic logic exp_buzz(input int k, input int h);
    return (k < NOTE_CYC) && (((k / h) % 2) == 0);
  endfunction

  // Runs cycles 1..n after a note start and counts deviations from the model
  task automatic play_window(input int h, input int n,
                             output int eb, output int ed, output int ey, output int first);
    eb = 0; ed = 0; ey = 0; first = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (buzz !== exp_buzz(k, h)) begin
        if (first < 0) first = k;
        eb++;
      end
      if (note_done !== (k == NOTE_CYC)) begin
        if (first < 0) first = k;
        ed++;
      end
      if (busy !== (k < NOTE_CYC + GAP_CYC)) begin
        if (first < 0) first = k;
        ey++;
      end
    end
  endtask

  task automatic test_reset();
    int errs;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    repeat (3) step();
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      key_code = 4'(k);
      if ({buzz, busy, note_idx, note_done} !== 7'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reset_idle: %0d cycles with nonzero outputs, required 0", errs);
    end
  endtask

  task automatic test_single_note();
    int eb, ed, ey, first;
    strobe(4'd5);
    total++;
    if ({buzz, busy, note_idx, note_done} !== {1'b1, 1'b1, 4'd5, 1'b0}) begin
      bad++;
      $display("FAIL t2_start: buzz=%b busy=%b idx=%0d done=%b, required 1 1 5 0",
               buzz, busy, note_idx, note_done);
    end
    play_window(1136, 3000, eb, ed, ey, first);
    total++;
    if (eb != 0) begin bad++; $display("FAIL t2_buzz: %0d bad cycles (first %0d), required 0", eb, first); end
    total++;
    if (ed != 0) begin bad++; $display("FAIL t2_done: %0d bad cycles (first %0d), required 0", ed, first); end
    total++;
    if (ey != 0) begin bad++; $display("FAIL t2_busy: %0d bad cycles (first %0d), required 0", ey, first); end
  endtask

  task automatic test_retrigger();
    int eb, ed, ey, first;
    strobe(4'd0);
    play_window(1908, 499, eb, ed, ey, first);
    total++;
    if (eb + ed + ey != 0) begin
      bad++;
      $display("FAIL t3_first: %0d bad samples (first %0d), required 0", eb + ed + ey, first);
    end
    strobe(4'd7);
    total++;
    if ({buzz, busy, note_idx, note_done} !== {1'b1, 1'b1, 4'd7, 1'b0}) begin
      bad++;
      $display("FAIL t3_restart: buzz=%b busy=%b idx=%0d done=%b, required 1 1 7 0",
               buzz, busy, note_idx, note_done);
    end
    play_window(956, 3000, eb, ed, ey, first);
    total++;
    if (eb != 0) begin bad++; $display("FAIL t3_buzz: %0d bad cycles (first %0d), required 0", eb, first); end
    total++;
    if (ed + ey != 0) begin bad++; $display("FAIL t3_done_busy: %0d bad cycles (first %0d), required 0", ed + ey, first); end
  endtask

  task automatic test_stop();
    int eb, ed, ey, first, errs;
    strobe(4'd14);
    play_window(477, 299, eb, ed, ey, first);
    total++;
    if (eb + ed + ey != 0) begin
      bad++;
      $display("FAIL t4_play: %0d bad samples (first %0d), required 0", eb + ed + ey, first);
    end
    strobe(4'd15);
    total++;
    if ({buzz, busy, note_idx, note_done} !== {1'b0, 1'b0, 4'd14, 1'b0}) begin
      bad++;
      $display("FAIL t4_stop: buzz=%b busy=%b idx=%0d done=%b, required 0 0 14 0",
               buzz, busy, note_idx, note_done);
    end
    errs = 0;
    for (int k = 0; k < 2500; k++) begin
      step();
      if ({buzz, busy, note_done} !== 3'b0 || note_idx !== 4'd14) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL t4_silent: %0d bad cycles, required 0", errs); end
    strobe(4'd15);
    total++;
    if ({buzz, busy, note_idx, note_done} !== {1'b0, 1'b0, 4'd14, 1'b0}) begin
      bad++;
      $display("FAIL t4_stop_idle: buzz=%b busy=%b idx=%0d done=%b, required 0 0 14 0",
               buzz, busy, note_idx, note_done);
    end
  endtask

  task automatic test_back_to_back();
    int eb, ed, ey, first;
    strobe(4'd2);
    play_window(1515, 1999, eb, ed, ey, first);
    total++;
    if (eb + ed + ey != 0) begin
      bad++;
      $display("FAIL t5_prior: %0d bad samples (first %0d), required 0", eb + ed + ey, first);
    end
    // this strobe lands on the prior note's terminal-count edge
    strobe(4'd3);
    total++;
    if ({buzz, busy, note_idx, note_done} !== {1'b1, 1'b1, 4'd3, 1'b0}) begin
      bad++;
      $display("FAIL t5_collide: buzz=%b busy=%b idx=%0d done=%b, required 1 1 3 0",
               buzz, busy, note_idx, note_done);
    end
    play_window(1432, 3000, eb, ed, ey, first);
    total++;
    if (eb + ed + ey != 0) begin
      bad++;
      $display("FAIL t5_new: %0d bad samples (first %0d), required 0", eb + ed + ey, first);
    end
  endtask

  task automatic test_reset_mid_play();
    int eb, ed, ey, first;
    strobe(4'd4);
    repeat (100) step();
    rst_n = 1'b0;
    step();
    total++;
    if ({buzz, busy, note_idx, note_done} !== 7'b0) begin
      bad++;
      $display("FAIL t6_reset: buzz=%b busy=%b idx=%0d done=%b, required 0 0 0 0",
               buzz, busy, note_idx, note_done);
    end
    rst_n = 1'b1;
    step();
    strobe(4'd9);
    total++;
    if ({buzz, busy, note_idx} !== {1'b1, 1'b1, 4'd9}) begin
      bad++;
      $display("FAIL t6_start: buzz=%b busy=%b idx=%0d, required 1 1 9", buzz, busy, note_idx);
    end
    // 1e6 / (2*659) floors to 758
    play_window(758, 3000, eb, ed, ey, first);
    total++;
    if (eb + ed + ey != 0) begin
      bad++;
      $display("FAIL t6_play: %0d bad samples (first %0d), required 0", eb + ed + ey, first);
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_retrigger();
    test_stop();
    test_back_to_back();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
